// File: rtl/sram_lat_model.sv
// sram_lat_model: cycle-accurate behavioural SRAM with a configurable word width,
// depth, beats per read and request-to-READY latency in clock cycles.
// A request is latched on accept. Writes commit and reads capture at the edge that
// enters DONE. Read data is driven onto the shared DQ bus only during the DONE cycle.
module sram_lat_model #(
  parameter int WORD_W    = 32,
  parameter int BEATS     = 2,
  parameter int ADDR_W    = 17,
  parameter int DEPTH     = 512,
  parameter int LAT       = 5,
  parameter int INIT_ZERO = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      SRAM_CE_N,
  input  logic                      SRAM_WE_N,
  input  logic [ADDR_W-1:0]         SRAM_ADDR,
  input  logic [WORD_W/8-1:0]       SRAM_BE_N,
  inout  wire  [WORD_W*BEATS-1:0]   SRAM_DQ,
  output logic                      SRAM_READY
);

  localparam int NB    = WORD_W / 8;
  localparam int BUS_W = WORD_W * BEATS;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(LAT) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_nxt_s;
  logic                 accept_s;
  logic                 commit_s;

  // Request captured at accept; later bus activity cannot disturb it
  logic                 we_n_r;
  logic [ADDR_W-1:0]    addr_r;
  logic [NB-1:0]        be_n_r;
  logic [WORD_W-1:0]    wdata_r;

  logic [BUS_W-1:0]     rdata_r;
  logic                 ready_r;
  logic                 drive_r;

  logic [IDX_W-1:0]     idx_s;
  logic [IDX_W-1:0]     base_s;

  // Contents survive reset. The declaration initialiser gives the time-zero contents.
  logic [WORD_W-1:0]    mem_r [DEPTH] =
    '{default: (INIT_ZERO != 0) ? {WORD_W{1'b0}} : {WORD_W{1'bx}}};

  // Upper address bits beyond the depth and the upper DQ lanes are intentionally unused
  wire unused_s = ^{addr_r, SRAM_DQ};

  // Addresses wrap modulo DEPTH. A read group is aligned down to a BEATS boundary.
  assign idx_s  = addr_r[IDX_W-1:0];
  assign base_s = idx_s & ~IDX_W'(BEATS - 1);

  // Next-state logic: accept in IDLE, count down in WAIT, single-cycle DONE
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!SRAM_CE_N) begin
          accept_s    = 1'b1;
          cnt_nxt_s   = CNT_W'(LAT - 1);
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          commit_s    = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s   = cnt_r - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Control state, latched request and the registered READY / bus-drive flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      we_n_r  <= 1'b1;
      addr_r  <= {ADDR_W{1'b0}};
      be_n_r  <= {NB{1'b1}};
      wdata_r <= {WORD_W{1'b0}};
      ready_r <= 1'b0;
      drive_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ready_r <= commit_s;
      drive_r <= commit_s & we_n_r;
      if (accept_s) begin
        we_n_r  <= SRAM_WE_N;
        addr_r  <= SRAM_ADDR;
        be_n_r  <= SRAM_BE_N;
        wdata_r <= SRAM_DQ[WORD_W-1:0];
      end
    end
  end

  // Memory commit and read capture at DONE entry. A same-edge reset aborts both.
  always_ff @(posedge clk) begin
    if (!rst && commit_s) begin
      if (!we_n_r) begin
        for (int b = 0; b < NB; b++) begin
          if (!be_n_r[b]) begin
            mem_r[idx_s][8*b +: 8] <= wdata_r[8*b +: 8];
          end
        end
      end else begin
        for (int j = 0; j < BEATS; j++) begin
          rdata_r[j*WORD_W +: WORD_W] <= mem_r[base_s | IDX_W'(j)];
        end
      end
    end
  end

  assign SRAM_DQ    = drive_r ? rdata_r : {BUS_W{1'bz}};
  assign SRAM_READY = ready_r;

endmodule
